// File: rtl/load_store_unit_if.sv
// Request (execute -> LSU) and bus (LSU -> memory) channels of the load/store unit.
interface lsu_req_if #(parameter int REG_ADDR_WIDTH = 4);
  logic                      req_valid;
  logic                      req_ready;
  logic [2:0]                req_op;
  logic [31:0]               req_addr;
  logic [31:0]               req_wdata;
  logic [REG_ADDR_WIDTH-1:0] req_rd;

  modport master (output req_valid, req_op, req_addr, req_wdata, req_rd, input req_ready);
  modport slave  (input req_valid, req_op, req_addr, req_wdata, req_rd, output req_ready);
endinterface

interface lsu_bus_if;
  logic        bus_valid;
  logic        bus_write;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic [3:0]  bus_wstrb;
  logic        bus_ready;
  logic [31:0] bus_rdata;
  logic        bus_error;

  modport master (output bus_valid, bus_write, bus_addr, bus_wdata, bus_wstrb,
                  input bus_ready, bus_rdata, bus_error);
  modport slave  (input bus_valid, bus_write, bus_addr, bus_wdata, bus_wstrb,
                  output bus_ready, bus_rdata, bus_error);
endinterface

// File: rtl/load_store_unit.sv
// Single-outstanding load/store unit: lane formatting, load extension, timeout and sticky fault.
// LSU_MISALIGN_TRAP_EN: misaligned requests fault instead of being aligned down.
module load_store_unit #(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int REG_ADDR_WIDTH = 4
) (
  input  logic                      clock,
  input  logic                      reset,
  lsu_req_if.slave                  req,
  lsu_bus_if.master                 bus,
  output logic                      rf_do_write,
  output logic [REG_ADDR_WIDTH-1:0] rf_write_loc,
  output logic [31:0]               rf_write_data,
  output logic                      busy,
  output logic                      fault,
  output logic [31:0]               fault_addr,
  input  logic                      fault_clear
);
  localparam int NUM_LANES = 4;
  localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] TO_LAST = CW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

  typedef enum logic [1:0] {IDLE, BUS, WRITEBACK, FAULT} state_t;
  typedef struct packed {
    logic [2:0]                op;
    logic [31:0]               addr;
    logic [REG_ADDR_WIDTH-1:0] rd;
  } req_t;

  state_t  state;
  req_t    cur;
  logic [CW-1:0] cnt;

  // Incoming request decode; offsets are already aligned down to the access size.
  logic in_store, in_half, in_word;
  logic [1:0] in_off;
  logic [NUM_LANES-1:0]      lane_strb;
  logic [NUM_LANES-1:0][7:0] lane_wdata;

  assign in_store = (req.req_op >= 3'd5);
  assign in_half  = (req.req_op == 3'd1) || (req.req_op == 3'd4) || (req.req_op == 3'd6);
  assign in_word  = (req.req_op == 3'd2) || (req.req_op == 3'd7);
  assign in_off   = in_word ? 2'b00 : in_half ? {req.req_addr[1], 1'b0} : req.req_addr[1:0];

`ifdef LSU_MISALIGN_TRAP_EN
  logic in_misaligned;
  assign in_misaligned = (in_half && req.req_addr[0]) || (in_word && (req.req_addr[1:0] != 2'b00));
`endif

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    assign lane_strb[i]  = in_store && (in_word || (in_half ? (in_off[1] == 1'(i / 2))
                                                            : (in_off == 2'(i))));
    assign lane_wdata[i] = !in_store ? 8'h00 :
                           in_word   ? req.req_wdata[8*i +: 8] :
                           in_half   ? req.req_wdata[8*(i%2) +: 8] :
                                       req.req_wdata[7:0];
  end

  // Load extraction from the latched op/address.
  logic [1:0]  ld_off;
  logic [31:0] ld_shift, ld_val;
  assign ld_off   = (cur.op == 3'd2) ? 2'b00 :
                    ((cur.op == 3'd1) || (cur.op == 3'd4)) ? {cur.addr[1], 1'b0} : cur.addr[1:0];
  assign ld_shift = bus.bus_rdata >> {ld_off, 3'b000};

  always_comb begin
    ld_val = ld_shift;
    case (cur.op)
      3'd0:    ld_val = {{24{ld_shift[7]}}, ld_shift[7:0]};
      3'd1:    ld_val = {{16{ld_shift[15]}}, ld_shift[15:0]};
      3'd3:    ld_val = {24'h0, ld_shift[7:0]};
      3'd4:    ld_val = {16'h0, ld_shift[15:0]};
      default: ld_val = ld_shift;
    endcase
  end

  logic timeout_hit;
  assign timeout_hit = (TIMEOUT_CYCLES != 0) && (cnt == TO_LAST);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      cur           <= '0;
      cnt           <= '0;
      req.req_ready <= 1'b1;
      bus.bus_valid <= 1'b0;
      bus.bus_write <= 1'b0;
      bus.bus_addr  <= '0;
      bus.bus_wdata <= '0;
      bus.bus_wstrb <= '0;
      rf_do_write   <= 1'b0;
      rf_write_loc  <= '0;
      rf_write_data <= '0;
      busy          <= 1'b0;
      fault         <= 1'b0;
      fault_addr    <= '0;
    end else begin
      case (state)
        IDLE: if (req.req_valid) begin
          cur           <= '{op: req.req_op, addr: req.req_addr, rd: req.req_rd};
          cnt           <= '0;
          req.req_ready <= 1'b0;
          busy          <= 1'b1;
`ifdef LSU_MISALIGN_TRAP_EN
          if (in_misaligned) begin
            state      <= FAULT;
            fault      <= 1'b1;
            fault_addr <= req.req_addr;
          end else
`endif
          begin
            state         <= BUS;
            bus.bus_valid <= 1'b1;
            bus.bus_write <= in_store;
            bus.bus_addr  <= {req.req_addr[31:2], 2'b00};
            bus.bus_wdata <= lane_wdata;
            bus.bus_wstrb <= lane_strb;
          end
        end
        BUS: if (bus.bus_ready) begin
          bus.bus_valid <= 1'b0;
          if (bus.bus_error) begin
            state      <= FAULT;
            fault      <= 1'b1;
            fault_addr <= cur.addr;
          end else if (bus.bus_write) begin
            state         <= IDLE;
            req.req_ready <= 1'b1;
            busy          <= 1'b0;
          end else begin
            state         <= WRITEBACK;
            rf_do_write   <= |cur.rd;
            rf_write_loc  <= cur.rd;
            rf_write_data <= ld_val;
          end
        end else if (timeout_hit) begin
          state         <= FAULT;
          bus.bus_valid <= 1'b0;
          fault         <= 1'b1;
          fault_addr    <= cur.addr;
        end else begin
          cnt <= cnt + 1'b1;
        end
        WRITEBACK: begin
          state         <= IDLE;
          rf_do_write   <= 1'b0;
          req.req_ready <= 1'b1;
          busy          <= 1'b0;
        end
        FAULT: if (fault_clear) begin
          state         <= IDLE;
          fault         <= 1'b0;
          req.req_ready <= 1'b1;
          busy          <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_load_store_unit.sv
// Randomized + directed bench for load_store_unit against a byte-level reference model.
module tb_load_store_unit;
  localparam int RAW = 4;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  logic           rf_do_write;
  logic [RAW-1:0] rf_write_loc;
  logic [31:0]    rf_write_data, fault_addr;
  logic           busy, fault, fault_clear;

  lsu_req_if #(.REG_ADDR_WIDTH(RAW)) rq();
  lsu_bus_if bs();

  load_store_unit #(.TIMEOUT_CYCLES(4), .REG_ADDR_WIDTH(RAW)) dut (
    .clock(clock), .reset(reset), .req(rq), .bus(bs),
    .rf_do_write(rf_do_write), .rf_write_loc(rf_write_loc), .rf_write_data(rf_write_data),
    .busy(busy), .fault(fault), .fault_addr(fault_addr), .fault_clear(fault_clear)
  );

  int n_run = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference model: access size in bytes, aligned-down offset, lane bytes.
  function automatic int op_size(input logic [2:0] op);
    case (op)
      3'd0, 3'd3, 3'd5: return 1;
      3'd1, 3'd4, 3'd6: return 2;
      default:          return 4;
    endcase
  endfunction

  function automatic int eff_off(input logic [2:0] op, input logic [31:0] addr);
    int a = int'(addr[1:0]);
    return a - (a % op_size(op));
  endfunction

  function automatic bit is_misaligned(input logic [2:0] op, input logic [31:0] addr);
    return (int'(addr[1:0]) % op_size(op)) != 0;
  endfunction

  task automatic ref_store(input logic [2:0] op, input logic [31:0] addr, input logic [31:0] wdata,
                           output logic [3:0] strb, output logic [31:0] wd);
    int sz = op_size(op);
    int off = eff_off(op, addr);
    strb = '0;
    wd = '0;
    for (int k = 0; k < sz; k++) strb[off + k] = 1'b1;
    for (int l = 0; l < 4; l++) wd[8*l +: 8] = wdata[8*(l % sz) +: 8];
  endtask

  function automatic logic [31:0] ref_load(input logic [2:0] op, input logic [31:0] addr,
                                           input logic [31:0] rdata);
    int sz = op_size(op);
    logic [31:0] mask = (sz == 4) ? 32'hFFFF_FFFF : ((32'h1 << (8*sz)) - 32'h1);
    logic [31:0] v = (rdata >> (8*eff_off(op, addr))) & mask;
    if ((op == 3'd0 || op == 3'd1) && v[8*sz-1]) v = v | ~mask;
    return v;
  endfunction

  task automatic clear_fault();
    fault_clear = 1'b1;
    @(negedge clock);
    fault_clear = 1'b0;
    chk("clr_fault", fault, 0);
    chk("clr_ready", rq.req_ready, 1);
    chk("clr_busy", busy, 0);
  endtask

  task automatic do_op(input logic [2:0] op, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [RAW-1:0] rd, input logic [31:0] rdata, input int dly,
                       input bit err);
    logic [3:0]  es;
    logic [31:0] ew;
    bit st = (op >= 3'd5);
    bit trap = 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
    trap = is_misaligned(op, addr);
`endif
    @(negedge clock);
    chk("idle_ready", rq.req_ready, 1);
    rq.req_valid = 1'b1; rq.req_op = op; rq.req_addr = addr; rq.req_wdata = wdata; rq.req_rd = rd;
    @(negedge clock);
    rq.req_valid = 1'b0;
    chk("acc_busy", busy, 1);
    chk("acc_ready", rq.req_ready, 0);
    if (trap) begin
      chk("trap_fault", fault, 1);
      chk("trap_nobus", bs.bus_valid, 0);
      chk("trap_addr", fault_addr, addr);
      clear_fault();
      return;
    end
    if (st) ref_store(op, addr, wdata, es, ew);
    else begin es = 4'h0; ew = 32'h0; end
    chk("bus_valid", bs.bus_valid, 1);
    chk("bus_addr", bs.bus_addr, {addr[31:2], 2'b00});
    chk("bus_write", bs.bus_write, st);
    chk("bus_wstrb", bs.bus_wstrb, es);
    if (st) chk("bus_wdata", bs.bus_wdata, ew);
    for (int i = 0; i < dly; i++) begin
      @(negedge clock);
      chk("bus_hold_valid", bs.bus_valid, 1);
      chk("bus_hold_strb", bs.bus_wstrb, es);
      chk("bus_no_fault", fault, 0);
    end
    bs.bus_ready = 1'b1; bs.bus_rdata = rdata; bs.bus_error = err;
    @(negedge clock);
    bs.bus_ready = 1'b0; bs.bus_error = 1'b0; bs.bus_rdata = $urandom;
    chk("bus_drop", bs.bus_valid, 0);
    if (err) begin
      chk("err_fault", fault, 1);
      chk("err_addr", fault_addr, addr);
      chk("err_ready", rq.req_ready, 0);
      clear_fault();
    end else if (st) begin
      chk("st_ready", rq.req_ready, 1);
      chk("st_nowr", rf_do_write, 0);
    end else begin
      chk("ld_wr", rf_do_write, (rd != 0));
      chk("ld_ready", rq.req_ready, 0);
      if (rd != 0) begin
        chk("ld_loc", rf_write_loc, rd);
        chk("ld_data", rf_write_data, ref_load(op, addr, rdata));
      end
      @(negedge clock);
      chk("ld_wr_end", rf_do_write, 0);
      chk("ld_ready_end", rq.req_ready, 1);
    end
  endtask

  initial begin
    rq.req_valid = 1'b0; rq.req_op = '0; rq.req_addr = '0; rq.req_wdata = '0; rq.req_rd = '0;
    bs.bus_ready = 1'b0; bs.bus_rdata = '0; bs.bus_error = 1'b0;
    fault_clear = 1'b0;
    repeat (2) @(negedge clock);
    chk("rst_ready", rq.req_ready, 1);
    chk("rst_bus_valid", bs.bus_valid, 0);
    chk("rst_wstrb", bs.bus_wstrb, 0);
    chk("rst_busy", busy, 0);
    chk("rst_fault", fault, 0);
    chk("rst_rfwr", rf_do_write, 0);
    reset = 1'b0;

    // Directed cases
    do_op(3'd7, 32'h100, 32'hDEADBEEF, 4'd0, 32'h0, 2, 1'b0);
    do_op(3'd5, 32'h203, 32'h000000A5, 4'd0, 32'h0, 0, 1'b0);
    do_op(3'd0, 32'h301, 32'h0, 4'd5, 32'h1234_80FF, 1, 1'b0);
    do_op(3'd3, 32'h301, 32'h0, 4'd5, 32'h1234_80FF, 0, 1'b0);
    do_op(3'd4, 32'h302, 32'h0, 4'd6, 32'h1234_80FF, 3, 1'b0);
    do_op(3'd1, 32'h101, 32'h0, 4'd3, 32'hABCD_8001, 0, 1'b0);
    do_op(3'd2, 32'h40, 32'h0, 4'd0, 32'h5555_AAAA, 1, 1'b0);
    do_op(3'd7, 32'h80, 32'h11223344, 4'd0, 32'h0, 1, 1'b1);

    // Timeout: four bus cycles without bus_ready
    @(negedge clock);
    rq.req_valid = 1'b1; rq.req_op = 3'd2; rq.req_addr = 32'h0000_0C40; rq.req_rd = 4'd7;
    @(negedge clock);
    rq.req_valid = 1'b0;
    repeat (3) @(negedge clock);
    chk("to_not_yet", fault, 0);
    chk("to_bus_still", bs.bus_valid, 1);
    @(negedge clock);
    chk("to_fault", fault, 1);
    chk("to_addr", fault_addr, 32'h0000_0C40);
    chk("to_bus_drop", bs.bus_valid, 0);
    clear_fault();

    // fault_clear while idle does nothing
    fault_clear = 1'b1;
    @(negedge clock);
    fault_clear = 1'b0;
    chk("clr_idle_fault", fault, 0);
    chk("clr_idle_ready", rq.req_ready, 1);

    // Reset in the middle of a load's bus phase
    rq.req_valid = 1'b1; rq.req_op = 3'd2; rq.req_addr = 32'h500; rq.req_rd = 4'd9;
    @(negedge clock);
    rq.req_valid = 1'b0;
    chk("mid_bus_valid", bs.bus_valid, 1);
    reset = 1'b1;
    #1;
    chk("mid_rst_bus", bs.bus_valid, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_ready", rq.req_ready, 1);
    @(negedge clock);
    reset = 1'b0;
    bs.bus_ready = 1'b1; bs.bus_rdata = 32'hCAFE_F00D;
    @(negedge clock);
    bs.bus_ready = 1'b0;
    chk("mid_no_wr0", rf_do_write, 0);
    @(negedge clock);
    chk("mid_no_wr1", rf_do_write, 0);
    chk("mid_busy", busy, 0);

    // Randomized traffic
    for (int n = 0; n < 80; n++) begin
      logic [2:0]     op = 3'($urandom_range(0, 7));
      logic [31:0]    addr = $urandom;
      logic [RAW-1:0] rd = RAW'($urandom_range(0, 15));
      do_op(op, addr, $urandom, rd, $urandom, $urandom_range(0, 3), ($urandom_range(0, 9) == 0));
    end

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
